// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: sweep FSM states and a width helper.
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned ctr_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter that measures the settle window; zero marks the last settle cycle.
module truth_table_checker_settle_timer
    import truth_table_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = ctr_width(SETTLE_CYCLES - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(SETTLE_CYCLES - 1);
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into a gate under test, compares each settled output with an
// expected truth table and reports pass/fail, mismatch count and the first failing vector.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int                      N_INPUTS      = 2,
    parameter logic [2**N_INPUTS-1:0]  EXPECTED      = 4'b1110,
    parameter int                      SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_INPUTS-1:0] stim,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic                first_fail_valid,
    output logic [N_INPUTS-1:0] first_fail_idx
);

    localparam int                NVEC = 2**N_INPUTS;
    localparam logic [N_INPUTS-1:0] LAST = N_INPUTS'(NVEC - 1);

    state_t              state;
    logic [N_INPUTS-1:0] idx;
    logic                timer_load;
    logic                timer_en;
    logic                timer_zero;
    logic                mismatch;

    // The timer is reloaded whenever a new vector begins its settle window.
    assign timer_load = (state == ST_IDLE && start) || (state == ST_SAMPLE && idx != LAST);
    assign timer_en   = (state == ST_SETTLE);

    // Case-inequality so an X/Z from the gate in simulation is reported as a mismatch.
    assign mismatch = (dut_out !== EXPECTED[idx]);

    // idx is itself a flop, so stim is glitch-free and stable for the whole vector window.
    assign stim = idx;

    truth_table_checker_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (timer_en),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            idx              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state            <= ST_SETTLE;
                        idx              <= '0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_idx   <= idx;
                        end
                    end
                    // Terminal compare comes before the increment, so idx never wraps.
                    if (idx == LAST) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checker configurations, table-driven gate models, and a
// reference model that derives expected verdicts directly from the gate truth tables.
module tb_truth_table_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    bit         sel   = 1'b0;

    logic       start_a, start_b;
    logic [1:0] stim_a, ffi_a;
    logic [2:0] err_a;
    logic       dut_out_a, busy_a, done_a, pass_a, ffv_a;
    logic [2:0] stim_b, ffi_b;
    logic [3:0] err_b;
    logic       dut_out_b, busy_b, done_b, pass_b, ffv_b;

    logic [3:0] tbl_a = 4'b1110;
    bit         xz_a  = 1'b0;
    logic [7:0] tbl_b = 8'h80;

    logic [2:0] o_stim, o_ffi;
    logic [3:0] o_err;
    logic       o_busy, o_done, o_pass, o_ffv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    always_comb dut_out_a = (xz_a && stim_a == 2'd0) ? 1'bx : tbl_a[stim_a];
    always_comb dut_out_b = tbl_b[stim_b];

    always_comb begin
        if (sel) begin
            o_stim = stim_b;  o_ffi = ffi_b;  o_err = err_b;
            o_busy = busy_b;  o_done = done_b; o_pass = pass_b; o_ffv = ffv_b;
        end else begin
            o_stim = {1'b0, stim_a}; o_ffi = {1'b0, ffi_a}; o_err = {1'b0, err_a};
            o_busy = busy_a;  o_done = done_a; o_pass = pass_a; o_ffv = ffv_a;
        end
    end

    truth_table_checker #(.N_INPUTS(2), .EXPECTED(4'b1110), .SETTLE_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_valid(ffv_a), .first_fail_idx(ffi_a)
    );

    truth_table_checker #(.N_INPUTS(3), .EXPECTED(8'h80), .SETTLE_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_valid(ffv_b), .first_fail_idx(ffi_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Config A checks a 2-input OR, config B a 3-input AND; gate output X counts as a miss.
    function automatic void ref_model(input bit is_b, input logic [7:0] tbl, input bit xz,
                                      output int err, output int ffi);
        int   nvec;
        logic g;
        logic e;
        nvec = is_b ? 8 : 4;
        err  = 0;
        ffi  = 0;
        for (int v = 0; v < nvec; v++) begin
            g = (xz && v == 0) ? 1'bx : tbl[v];
            e = is_b ? (v == nvec - 1) : (v != 0);
            if (g !== e) begin
                if (err == 0) ffi = v;
                err++;
            end
        end
    endfunction

    task automatic run_sweep(input bit s, input logic [7:0] tbl, input bit xz,
                             input bit poke, input string tag);
        int settle, nvec, total, cnt, stim_bad, err, ffi;
        settle = s ? 3 : 1;
        nvec   = s ? 8 : 4;
        total  = nvec * (settle + 1);
        ref_model(s, tbl, xz, err, ffi);
        sel = s;
        if (s) tbl_b = tbl;
        else begin
            tbl_a = tbl[3:0];
            xz_a  = xz;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cnt      = 0;
        stim_bad = 0;
        while (o_done !== 1'b1 && cnt < total + 20) begin
            if (cnt < total && (o_stim !== 3'(cnt / (settle + 1)) || o_busy !== 1'b1))
                stim_bad++;
            if (poke && (cnt == 2 || cnt == total)) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cnt++;
        end
        check({tag, "_latency"}, cnt, total + 1);
        check({tag, "_stim_seq"}, stim_bad, 0);
        check({tag, "_busy_at_done"}, o_busy, 1'b0);
        check({tag, "_pass"}, o_pass, (err == 0));
        check({tag, "_err_count"}, o_err, err);
        check({tag, "_ff_valid"}, o_ffv, (err != 0));
        check({tag, "_ff_idx"}, o_ffi, ffi);
        check({tag, "_stim_hold"}, o_stim, nvec - 1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, o_done, 1'b0);
        check({tag, "_idle_after"}, o_busy, 1'b0);
        check({tag, "_pass_held"}, o_pass, (err == 0));
    endtask

    initial begin
        int  wait_cnt;
        bit  done_seen;
        bit  rs;
        logic [7:0] rt;
        bit  rx;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_stim", o_stim, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_pass", o_pass, 0);
        check("rst_err", o_err, 0);
        check("rst_ffv", o_ffv, 0);
        check("rst_ffi", o_ffi, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sweeps
        run_sweep(1'b0, 8'h0E, 1'b0, 1'b0, "or_pass");
        run_sweep(1'b0, 8'h00, 1'b0, 1'b0, "stuck0");
        run_sweep(1'b0, 8'h0E, 1'b0, 1'b1, "start_ignored");
        run_sweep(1'b0, 8'h0E, 1'b1, 1'b0, "x_vec0");
        run_sweep(1'b1, 8'h80, 1'b0, 1'b0, "and3");

        // Reset mid-sweep once idx reaches 2, with one mismatch already recorded
        sel   = 1'b0;
        tbl_a = 4'b0000;
        xz_a  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        wait_cnt = 0;
        while (o_stim !== 3'd2 && wait_cnt < 50) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check("abort_reached_idx2", o_stim, 2);
        check("abort_err_before", o_err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_stim", o_stim, 0);
        check("abort_busy", o_busy, 0);
        check("abort_err", o_err, 0);
        check("abort_ffv", o_ffv, 0);
        done_seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (o_done === 1'b1) done_seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_done", done_seen, 1'b0);
        run_sweep(1'b0, 8'h0E, 1'b0, 1'b0, "after_abort");

        // Randomized gate tables against the reference model
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            rt = 8'($urandom);
            rx = rs ? 1'b0 : 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_sweep(rs, rt, rx, 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
